book_request_arbiter: RTL and testbench
=======================================

Name: book_request_arbiter

Overview:
- Shares the single book_builder command port between N_REQ independent requesters (feed parser lanes, local cancel logic).
- Round-robin arbitration: one command at a time, converted into the builder's start/request strobe, then waits for builder completion or timeout and returns per-requester status.
- Sits between the feed-decode front end and book_builder, inside the book/trade top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 64, max cycles waiting for bb_done before forced error completion.
- CMD_W, width of book_cmd_t from book_pkg; not overridable.

Ports:
- clk_100mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has a command.
- req_cmd  in  N_REQ x CMD_W  packed book_cmd_t per requester.
- req_ready  out  N_REQ  one-hot accept; handshake completes when valid & ready.
- resp_valid  out  N_REQ  one-hot, one-cycle completion to command owner.
- resp_error  out  1  qualifies resp_valid: builder error, illegal opcode or timeout.
- resp_timeout  out  1  qualifies resp_valid: completion caused by timeout.
- hold  in  1  sampled only in IDLE; 1 blocks new grants.
- bb_start  out  1  one-cycle start strobe to builder.
- bb_request  out  3  opcode.
- bb_stock  out  STOCK_W  stock index.
- bb_order_id  out  ORDER_W  order id.
- bb_quantity  out  QTY_W  quantity.
- bb_price  out  PRICE_W  price.
- bb_delete  out  1  1 for CANCEL.
- bb_done  in  1  builder completion pulse.
- bb_error  in  1  sampled with bb_done.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs registered. Reset (async, reset_n=0): state IDLE, all outputs 0, rr pointer 0, timeout counter 0. Reset asserted mid-operation abandons the command with no response; builder is reset by the same net.
- Opcodes: ADD=3'd0, CANCEL=3'd1, TRADE=3'd2, 3..7 illegal.
- IDLE: if !hold and any req_valid, grant the first valid index at or after rr_ptr, wrapping modulo N_REQ. Assert req_ready[g] for exactly that cycle; latch cmd and owner g; rr_ptr <= (g+1) mod N_REQ.
  - Legal opcode -> ISSUE.
  - Illegal opcode -> RESP with error=1; no bb_start.
- ISSUE (1 cycle): bb_start=1; bb_* driven from latched cmd.
  - bb_delete = (opcode==CANCEL).
  - bb_* fields hold the latched value until the next grant.
  - Clear counter -> WAIT.
- WAIT:
  - bb_done=1: capture bb_error -> RESP.
  - Otherwise counter increments; counter==TIMEOUT_CYC-1 without done -> RESP with error=1, timeout=1.
  - bb_done arriving in the same cycle as the last timeout cycle counts as done, not timeout.
  - Stray bb_done outside WAIT is ignored.
- RESP (1 cycle): resp_valid[owner]=1 with resp_error and resp_timeout -> IDLE.
- Latency: grant to bb_start is 1 cycle. Minimum grant to resp_valid is 3 cycles (done on the first WAIT cycle). Back-to-back grants are at least 4 cycles apart. Illegal opcode completes in 2 cycles.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- hold does not affect a command already granted.
- req_ready is never asserted to a requester with req_valid=0; at most one req_ready bit high.

Decomposition:
- book_pkg:
  - STOCK_W=2, PRICE_W=16, ORDER_W=16, QTY_W=16.
  - Opcode localparams.
  - book_cmd_t packed struct {opcode, stock, order_id, quantity, price}.
  - Arbiter state enum.
- One sub-module: rr_arbiter (combinational pick of first valid at or after ptr, one-hot grant plus index).
- Everything else, including the FSM and timeout counter, lives in book_request_arbiter.

Test Plan:
- Single ADD: req 0 valid with {ADD, stock 1, id 0x0012, qty 100, price 0x1F40}; bb_done 2 cycles after bb_start -> bb_start 1 cycle after ready; bb_* match; resp_valid=4'b0001, error=0.
- Round-robin: all 4 valid continuously, done always immediate -> grant order 0,1,2,3,0; each resp_valid goes to the matching owner.
- Illegal opcode 3'd5 on req 2 -> req_ready[2], no bb_start, resp_valid[2] with error=1 two cycles after grant.
- Timeout: TIMEOUT_CYC=8, bb_done never arrives -> resp_valid with error=1, timeout=1 after 8 WAIT cycles. Repeat with done on the 8th cycle -> error=bb_error, timeout=0.
- hold=1 with req 1 valid -> no grant. Release hold -> grant next cycle. Raising hold during WAIT still lets the in-flight command complete.
- reset_n low during WAIT -> all outputs 0 immediately, no resp_valid. After release, the pending requester is re-granted from rr_ptr 0.

Source files
------------

// File: rtl/book_pkg.sv
// book_pkg: shared types and widths for the book request path.
//   - Field widths of a book command (stock, order id, quantity, price).
//   - Opcode encodings understood by book_builder.
//   - book_cmd_t: packed command word carried from each requester.
//   - arb_state_t: state encoding of book_request_arbiter.
package book_pkg;

  localparam int STOCK_W = 2;
  localparam int PRICE_W = 16;
  localparam int ORDER_W = 16;
  localparam int QTY_W   = 16;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_CANCEL = 3'd1;
  localparam logic [2:0] OP_TRADE  = 3'd2;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [STOCK_W-1:0] stock;
    logic [ORDER_W-1:0] order_id;
    logic [QTY_W-1:0]   quantity;
    logic [PRICE_W-1:0] price;
  } book_cmd_t;

  localparam int CMD_W = $bits(book_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  // Opcodes 3..7 are not understood by the builder.
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_TRADE;
  endfunction

endpackage

// File: rtl/book_request_arbiter_if.sv
// book_request_arbiter_if: requester-side bus of the book request arbiter.
//   req_valid    requester i holds a command
//   req_cmd      packed book_cmd_t per requester
//   req_ready    one-hot accept; handshake completes on valid & ready
//   resp_valid   one-hot, one-cycle completion to the command owner
//   resp_error   qualifies resp_valid: builder error, illegal opcode or timeout
//   resp_timeout qualifies resp_valid: completion caused by timeout
// master = requester side, slave = arbiter side.
interface book_request_arbiter_if
  import book_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic      [N_REQ-1:0] req_valid;
  book_cmd_t [N_REQ-1:0] req_cmd;
  logic      [N_REQ-1:0] req_ready;
  logic      [N_REQ-1:0] resp_valid;
  logic                  resp_error;
  logic                  resp_timeout;

  modport master (
    output req_valid, req_cmd,
    input  req_ready, resp_valid, resp_error, resp_timeout
  );

  modport slave (
    input  req_valid, req_cmd,
    output req_ready, resp_valid, resp_error, resp_timeout
  );

endinterface

// File: rtl/book_request_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   valid  request vector
//   ptr    highest-priority index this round
//   any    at least one request is valid
//   grant  one-hot of the first valid index at or after ptr (wrapping)
//   idx    binary index of the granted requester
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output gets a default before the loop so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    int j;
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/book_request_arbiter.sv
// book_request_arbiter: shares the single book_builder command port among
// N_REQ requesters with round-robin arbitration, one command in flight.
//   clk_100mhz, reset_n  system clock, asynchronous active-low reset
//   req                  requester bus (slave side of book_request_arbiter_if)
//   hold                 sampled only while idle; 1 blocks new grants
//   bb_start             one-cycle start strobe to the builder
//   bb_request..bb_delete  command fields, stable until the next grant
//   bb_done, bb_error    builder completion pulse and its error flag
//   busy                 arbiter is not idle
module book_request_arbiter
  import book_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk_100mhz,
  input  logic                reset_n,
  book_request_arbiter_if.slave req,
  input  logic                hold,
  output logic                bb_start,
  output logic [2:0]          bb_request,
  output logic [STOCK_W-1:0]  bb_stock,
  output logic [ORDER_W-1:0]  bb_order_id,
  output logic [QTY_W-1:0]    bb_quantity,
  output logic [PRICE_W-1:0]  bb_price,
  output logic                bb_delete,
  input  logic                bb_done,
  input  logic                bb_error,
  output logic                busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q;
  logic             err_q;
  logic             tmo_q;

  logic             pick_any;
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  book_cmd_t        sel_cmd;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .valid (req.req_valid),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign sel_cmd = req.req_cmd[pick_idx];

  // NOTE: all state and outputs live in flops updated with non-blocking
  // assignments, so every read in this block sees the pre-edge value.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every flop here is control or a small output register, so all
      // are reset; an abandoned command simply vanishes with no response.
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      owner            <= '0;
      cnt              <= '0;
      illegal_q        <= 1'b0;
      err_q            <= 1'b0;
      tmo_q            <= 1'b0;
      busy             <= 1'b0;
      bb_start         <= 1'b0;
      bb_request       <= '0;
      bb_stock         <= '0;
      bb_order_id      <= '0;
      bb_quantity      <= '0;
      bb_price         <= '0;
      bb_delete        <= 1'b0;
      req.req_ready    <= '0;
      req.resp_valid   <= '0;
      req.resp_error   <= 1'b0;
      req.resp_timeout <= 1'b0;
    end else begin
      // Strobes default low; the states below raise them for one cycle.
      req.req_ready    <= '0;
      req.resp_valid   <= '0;
      req.resp_error   <= 1'b0;
      req.resp_timeout <= 1'b0;
      bb_start         <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!hold && pick_any) begin
            req.req_ready <= pick_grant;
            owner         <= pick_idx;
            rr_ptr        <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            // Builder fields load at grant and hold until the next grant.
            bb_request    <= sel_cmd.opcode;
            bb_stock      <= sel_cmd.stock;
            bb_order_id   <= sel_cmd.order_id;
            bb_quantity   <= sel_cmd.quantity;
            bb_price      <= sel_cmd.price;
            bb_delete     <= (sel_cmd.opcode == OP_CANCEL);
            illegal_q     <= !is_legal_op(sel_cmd.opcode);
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt <= '0;
          if (illegal_q) begin
            // Illegal opcodes never reach the builder.
            err_q <= 1'b1;
            tmo_q <= 1'b0;
            state <= ST_RESP;
          end else begin
            bb_start <= 1'b1;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Done takes priority over the final timeout cycle.
          if (bb_done) begin
            err_q <= bb_error;
            tmo_q <= 1'b0;
            state <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_q <= 1'b1;
            tmo_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          req.resp_valid   <= N_REQ'(1) << owner;
          req.resp_error   <= err_q;
          req.resp_timeout <= tmo_q;
          busy             <= 1'b0;
          state            <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_book_request_arbiter.sv
// Testbench for book_request_arbiter: a transaction-level model predicts
// each grant, builder command and response (with cycle tags) into queues;
// independent monitor and builder processes pop and compare.
module tb_book_request_arbiter;
  import book_pkg::*;

  localparam int N       = 4;
  localparam int T       = 8;
  localparam int K_NEVER = 1000;

  logic clk_100mhz = 1'b0;
  logic reset_n    = 1'b0;
  logic hold       = 1'b0;
  logic bb_done    = 1'b0;
  logic bb_error   = 1'b0;
  logic               bb_start;
  logic [2:0]         bb_request;
  logic [STOCK_W-1:0] bb_stock;
  logic [ORDER_W-1:0] bb_order_id;
  logic [QTY_W-1:0]   bb_quantity;
  logic [PRICE_W-1:0] bb_price;
  logic               bb_delete;
  logic               busy;

  logic      [N-1:0] req_v = '0;
  book_cmd_t [N-1:0] req_c = '0;
  logic      [N-1:0] refill = '0;
  logic      [N-1:0] seen = '0;
  bit  rand_mode  = 1'b0;
  bit  legal_only = 1'b1;
  int  plan_k     = 1;
  bit  plan_err   = 1'b0;

  book_request_arbiter_if #(.N_REQ(N)) rq ();
  assign rq.req_valid = req_v;
  assign rq.req_cmd   = req_c;

  book_request_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk_100mhz  (clk_100mhz),
    .reset_n     (reset_n),
    .req         (rq.slave),
    .hold        (hold),
    .bb_start    (bb_start),
    .bb_request  (bb_request),
    .bb_stock    (bb_stock),
    .bb_order_id (bb_order_id),
    .bb_quantity (bb_quantity),
    .bb_price    (bb_price),
    .bb_delete   (bb_delete),
    .bb_done     (bb_done),
    .bb_error    (bb_error),
    .busy        (busy)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct { int tag; logic [N-1:0] onehot; } grant_t;
  typedef struct { int tag; logic [N-1:0] onehot; logic err; logic tmo; } resp_t;
  typedef struct { int tag; int k; logic err; book_cmd_t cmd; } plan_t;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];
  plan_t  bb_plan[$];

  int cyc    = 0;
  int m_ptr  = 0;
  int m_free = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic book_cmd_t rand_cmd(input bit legal);
    book_cmd_t c;
    if (legal || $urandom_range(0, 4) != 0) c.opcode = 3'($urandom_range(0, 2));
    else                                    c.opcode = 3'($urandom_range(3, 7));
    c.stock    = STOCK_W'($urandom);
    c.order_id = ORDER_W'($urandom);
    c.quantity = QTY_W'($urandom);
    c.price    = PRICE_W'($urandom);
    return c;
  endfunction

  // Reference model: an idle arbiter grants the first valid requester at or
  // after its pointer; the response lands 2 cycles after the grant for an
  // illegal opcode, or 2 + k cycles when done arrives on WAIT cycle k
  // (k capped at T for a timeout). The next grant can follow one cycle later.
  initial begin
    forever begin
      @(posedge clk_100mhz);
      cyc++;
      if (!reset_n) begin
        m_ptr  = 0;
        m_free = 0;
      end else if (cyc >= m_free && !hold && req_v != '0) begin
        int g;
        int k;
        bit e;
        g = -1;
        for (int i = 0; i < N; i++)
          if (g < 0 && req_v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        exp_grant.push_back('{cyc, N'(1) << g});
        m_ptr = (g + 1) % N;
        if (req_c[g].opcode > OP_TRADE) begin
          exp_resp.push_back('{cyc + 2, N'(1) << g, 1'b1, 1'b0});
          m_free = cyc + 3;
        end else begin
          if (plan_k == 0) begin
            k = $urandom_range(1, T + 1);
            e = 1'($urandom_range(0, 1));
          end else begin
            k = plan_k;
            e = plan_err;
          end
          bb_plan.push_back('{cyc + 1, k, e, req_c[g]});
          if (k <= T) begin
            exp_resp.push_back('{cyc + k + 2, N'(1) << g, e, 1'b0});
            m_free = cyc + k + 3;
          end else begin
            exp_resp.push_back('{cyc + T + 2, N'(1) << g, 1'b1, 1'b1});
            m_free = cyc + T + 3;
          end
        end
      end
    end
  end

  // Builder model: checks each start strobe, then pulses done on the planned
  // WAIT cycle (k = T+1 lands in the response cycle and must be ignored).
  initial begin
    forever begin
      @(negedge clk_100mhz);
      if (reset_n && bb_start) begin
        if (bb_plan.size() == 0) begin
          check("unexpected_bb_start", 64'(bb_start), 64'd0);
        end else begin
          plan_t p;
          p = bb_plan.pop_front();
          check("bb_start_cycle", 64'(cyc), 64'(p.tag));
          check("bb_fields", 64'({bb_request, bb_stock, bb_order_id, bb_quantity, bb_price}), 64'(p.cmd));
          check("bb_delete", 64'(bb_delete), 64'(p.cmd.opcode == OP_CANCEL));
          if (p.k <= T + 1) begin
            repeat (p.k - 1) @(negedge clk_100mhz);
            bb_done  = 1'b1;
            bb_error = p.err;
            @(negedge clk_100mhz);
            bb_done  = 1'b0;
            bb_error = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expected grants/responses whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk_100mhz);
      if (reset_n) begin
        check("busy", 64'(busy), 64'(cyc < m_free - 1));
        if (rq.req_ready != '0) begin
          check("ready_without_valid", 64'(rq.req_ready & ~req_v), 64'd0);
          if (exp_grant.size() == 0) begin
            check("unexpected_grant", 64'(rq.req_ready), 64'd0);
          end else begin
            grant_t g;
            g = exp_grant.pop_front();
            check("grant_onehot", 64'(rq.req_ready), 64'(g.onehot));
            check("grant_cycle", 64'(cyc), 64'(g.tag));
          end
        end
        if (rq.resp_valid != '0) begin
          if (exp_resp.size() == 0) begin
            check("unexpected_resp", 64'(rq.resp_valid), 64'd0);
          end else begin
            resp_t r;
            r = exp_resp.pop_front();
            check("resp_onehot", 64'(rq.resp_valid), 64'(r.onehot));
            check("resp_cycle", 64'(cyc), 64'(r.tag));
            check("resp_error", 64'(rq.resp_error), 64'(r.err));
            check("resp_timeout", 64'(rq.resp_timeout), 64'(r.tmo));
          end
        end
      end
    end
  end

  // One requester-side cycle: retire completed handshakes, optionally raise
  // new commands, record which requesters saw ready this cycle.
  task automatic step();
    @(negedge clk_100mhz);
    for (int i = 0; i < N; i++) begin
      if (seen[i]) begin
        req_v[i] = 1'b0;
        if (refill[i]) begin
          req_c[i] = rand_cmd(legal_only);
          req_v[i] = 1'b1;
        end
      end else if (rand_mode && !req_v[i] && $urandom_range(0, 3) == 0) begin
        req_c[i] = rand_cmd(legal_only);
        req_v[i] = 1'b1;
      end
      seen[i] = rq.req_ready[i];
    end
    if (rand_mode) hold = ($urandom_range(0, 7) == 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_v != '0 || exp_grant.size() != 0 || exp_resp.size() != 0 ||
            bb_plan.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (2) step();
    check("drain_pending",
          64'(exp_grant.size() + exp_resp.size() + bb_plan.size() + $countones(req_v)), 64'd0);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (!bb_start && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(bb_start), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_100mhz);
    check("reset_ctrl", 64'({rq.req_ready, rq.resp_valid, rq.resp_error, rq.resp_timeout,
                             bb_start, bb_delete, busy}), 64'd0);
    check("reset_bb_fields", 64'({bb_request, bb_stock, bb_order_id, bb_quantity, bb_price}), 64'd0);
    reset_n = 1'b1;

    // Round-robin from pointer 0 with every requester continuously valid.
    for (int i = 0; i < N; i++) req_c[i] = rand_cmd(1'b1);
    req_v  = '1;
    refill = '1;
    plan_k = 1;
    repeat (20) step();
    refill = '0;
    drain(60);

    // Single ADD on requester 0, done two cycles after bb_start.
    req_c[0] = '{OP_ADD, 2'd1, 16'h0012, 16'd100, 16'h1F40};
    req_v[0] = 1'b1;
    plan_k   = 3;
    drain(30);

    // CANCEL on requester 1 with a builder error.
    req_c[1] = rand_cmd(1'b1);
    req_c[1].opcode = OP_CANCEL;
    req_v[1]  = 1'b1;
    plan_k    = 1;
    plan_err  = 1'b1;
    drain(30);
    plan_err  = 1'b0;

    // Illegal opcode on requester 2.
    req_c[2] = rand_cmd(1'b1);
    req_c[2].opcode = 3'd5;
    req_v[2] = 1'b1;
    drain(30);

    // Timeout with no done, done on the last WAIT cycle, and a stray done.
    req_c[3] = rand_cmd(1'b1);
    req_v[3] = 1'b1;
    plan_k   = K_NEVER;
    drain(40);
    req_c[0] = rand_cmd(1'b1);
    req_v[0] = 1'b1;
    plan_k   = T;
    plan_err = 1'b1;
    drain(40);
    req_c[1] = rand_cmd(1'b1);
    req_v[1] = 1'b1;
    plan_k   = T + 1;
    plan_err = 1'b0;
    drain(40);

    // hold blocks grants while idle but not an in-flight command.
    plan_k   = 2;
    hold     = 1'b1;
    req_c[1] = rand_cmd(1'b1);
    req_v[1] = 1'b1;
    repeat (6) step();
    check("hold_blocks_grant", 64'({busy, rq.req_ready}), 64'd0);
    hold = 1'b0;
    wait_start("hold_release_start", 10);
    hold = 1'b1;
    drain(30);
    hold = 1'b0;

    // Reset during WAIT abandons the command; re-grant starts at pointer 0.
    req_c[2] = rand_cmd(1'b1);
    req_v[2] = 1'b1;
    plan_k   = K_NEVER;
    wait_start("reset_test_start", 20);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", 64'({rq.req_ready, rq.resp_valid, rq.resp_error, rq.resp_timeout,
                                bb_start, bb_delete, busy}), 64'd0);
    check("midreset_bb_fields", 64'({bb_request, bb_stock, bb_order_id, bb_quantity, bb_price}), 64'd0);
    exp_grant.delete();
    exp_resp.delete();
    bb_plan.delete();
    seen = '0;
    for (int i = 1; i < N; i++) req_c[i] = rand_cmd(1'b1);
    req_v  = 4'b1110;
    plan_k = 1;
    repeat (3) step();
    reset_n = 1'b1;
    drain(40);

    // Randomized traffic: random arrivals, hold, opcodes and builder latency.
    rand_mode  = 1'b1;
    legal_only = 1'b0;
    plan_k     = 0;
    repeat (400) step();
    rand_mode = 1'b0;
    hold      = 1'b0;
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
